// File: rtl/wb_master_seq.sv
// wb_master_seq: command/response handshake to single Wishbone cycles with a bounded ACK timeout; define WBM_RETRY_EN to re-issue a timed-out cycle once
module wb_master_seq #(
  parameter int ADDRWIDTH = 17,
  parameter int DATAWIDTH = 32,
  parameter int TIMEOUT_W = 4,
  parameter int TIMEOUT_CYCLES = 15,
  parameter logic [DATAWIDTH-1:0] ERR_READ_VALUE = 32'hDEAD_0BAD
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_n_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic [ADDRWIDTH-1:0] cmd_adr_i,
  input  logic [3:0]           cmd_byte_stb_i,
  input  logic [DATAWIDTH-1:0] cmd_dat_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DATAWIDTH-1:0] rsp_dat_o,
  output logic                 rsp_err_o,
  output logic [ADDRWIDTH-1:0] WBs_ADR_o,
  output logic                 WBs_CYC_o,
  output logic                 WBs_STB_o,
  output logic                 WBs_WE_o,
  output logic                 WBs_RD_o,
  output logic [3:0]           WBs_BYTE_STB_o,
  output logic [DATAWIDTH-1:0] WBs_WR_DAT_o,
  input  logic [DATAWIDTH-1:0] WBs_RD_DAT_i,
  input  logic                 WBs_ACK_i
);
  typedef enum logic [1:0] {IDLE, BUS, GAP, RESP} state_t;
  state_t state_q, state_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [DATAWIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic [ADDRWIDTH-1:0] adr_q, adr_d;
  logic                 cyc_q, cyc_d;
  logic                 we_o_q, we_o_d;
  logic                 rd_q, rd_d;
  logic [3:0]           bstb_q, bstb_d;
  logic [DATAWIDTH-1:0] wdat_q, wdat_d;
  logic                 we_lat_q, we_lat_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic accept, ack_hit, tmo, hs, retry_go, exit_resp;
  assign accept  = cmd_valid_i & cmd_ready_q;
  assign ack_hit = (state_q == BUS) & WBs_ACK_i;
  assign tmo     = (state_q == BUS) & ~WBs_ACK_i & (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES));
  assign hs      = (state_q == RESP) & rsp_ready_i;
`ifdef WBM_RETRY_EN
  logic retried_q, retried_d;
  assign retry_go  = tmo & ~retried_q;
  assign retried_d = accept ? 1'b0 : (retry_go ? 1'b1 : retried_q);
  // Remembers that the current command has already used its single retry
  always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i)
    if (!WBs_RST_n_i) retried_q <= 1'b0;
    else retried_q <= retried_d;
`else
  assign retry_go = 1'b0;
`endif
  // State register
  always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i)
    if (!WBs_RST_n_i) state_q <= IDLE;
    else state_q <= state_d;
  // Next-state: ACK beats a simultaneous timeout; a retry passes through a one-cycle gap
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = accept ? BUS : IDLE;
      BUS:  state_d = ack_hit ? RESP : (retry_go ? GAP : (tmo ? RESP : BUS));
      GAP:  state_d = BUS;
      RESP: state_d = hs ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  assign exit_resp = (state_q == BUS) & (state_d == RESP);
  // Output/datapath next values: bus signals follow the next state so they leave the flops directly
  always_comb begin
    cmd_ready_d = state_d == IDLE;
    we_lat_d    = accept ? cmd_we_i : we_lat_q;
    cyc_d       = state_d == BUS;
    we_o_d      = (state_d == BUS) & we_lat_d;
    rd_d        = (state_d == BUS) & ~we_lat_d;
    adr_d       = accept ? (cmd_adr_i & ~ADDRWIDTH'(3)) : adr_q;
    bstb_d      = accept ? (cmd_we_i ? cmd_byte_stb_i : 4'hF) : bstb_q;
    wdat_d      = accept ? cmd_dat_i : wdat_q;
    cnt_d       = (state_q == BUS && state_d == BUS) ? cnt_q + TIMEOUT_W'(1) :
                  (state_d == IDLE || state_d == GAP) ? '0 : cnt_q;
    rsp_valid_d = exit_resp ? 1'b1 : (hs ? 1'b0 : rsp_valid_q);
    rsp_err_d   = exit_resp ? ~WBs_ACK_i : rsp_err_q;
    rsp_dat_d   = exit_resp ? (we_lat_q ? '0 : (WBs_ACK_i ? WBs_RD_DAT_i : ERR_READ_VALUE)) : rsp_dat_q;
  end
  // Registered outputs and latched command
  always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i)
    if (!WBs_RST_n_i) begin
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= '0;
      adr_q       <= '0;
      cyc_q       <= 1'b0;
      we_o_q      <= 1'b0;
      rd_q        <= 1'b0;
      bstb_q      <= '0;
      wdat_q      <= '0;
      we_lat_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_dat_q   <= rsp_dat_d;
      adr_q       <= adr_d;
      cyc_q       <= cyc_d;
      we_o_q      <= we_o_d;
      rd_q        <= rd_d;
      bstb_q      <= bstb_d;
      wdat_q      <= wdat_d;
      we_lat_q    <= we_lat_d;
      cnt_q       <= cnt_d;
    end
  assign cmd_ready_o    = cmd_ready_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_err_o      = rsp_err_q;
  assign rsp_dat_o      = rsp_dat_q;
  assign WBs_ADR_o      = adr_q;
  assign WBs_CYC_o      = cyc_q;
  assign WBs_STB_o      = cyc_q;
  assign WBs_WE_o       = we_o_q;
  assign WBs_RD_o       = rd_q;
  assign WBs_BYTE_STB_o = bstb_q;
  assign WBs_WR_DAT_o   = wdat_q;
endmodule
